// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the sequential multiply/divide unit.
//   op_e     : operation encoding carried on the 'op' port (0 = multiply,
//              1 = divide).
//   state_e  : handshake/iteration state machine of seq_muldiv.
//   cnt_width: width of the iteration down-counter for a given operand width.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // The counter must hold WIDTH-1; clamp to one bit so degenerate widths
    // still produce a legal vector.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One radix-2 iteration of either an unsigned shift-add multiply or an
// unsigned restoring divide. Purely combinational; the caller registers the
// accumulator pair between iterations.
//
// Ports
//   op       in  1      0 = multiply step, 1 = divide step
//   acc_hi   in  WIDTH  multiply: partial product upper half
//                       divide  : partial remainder
//   acc_lo   in  WIDTH  multiply: remaining multiplier bits / product low half
//                       divide  : remaining dividend bits / quotient bits
//   operand  in  WIDTH  multiplicand or divisor (constant over an operation)
//   next_hi  out WIDTH  acc_hi after this iteration
//   next_lo  out WIDTH  acc_lo after this iteration
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             op,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        // Multiply: conditionally add the multiplicand into the upper half,
        // then shift the whole {carry, hi, lo} right by one. The bit shifted
        // out of lo is the multiplier bit just consumed.
        add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);

        // Divide: bring the next dividend bit (MSB of lo) into the remainder.
        // The remainder is always < divisor, so 2*rem+1 fits in WIDTH+1 bits.
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        fits    = (shifted >= {1'b0, operand});
        // When the trial subtraction fits, the result is < divisor and so
        // fits in WIDTH bits; the modular WIDTH-bit difference is exact.
        diff    = shifted[WIDTH-1:0] - operand;

        next_hi = acc_hi;
        next_lo = acc_lo;

        if (op == OP_MUL) begin
            next_hi = add_sum[WIDTH:1];
            next_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
        end else if (fits) begin
            next_hi = diff;
            next_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            next_hi = shifted[WIDTH-1:0];
            next_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_muldiv.sv
// -----------------------------------------------------------------------------
// seq_muldiv
// Sequential unsigned multiplier / divider, one result bit per clock.
// A request is taken with a valid/ready handshake, iterated WIDTH times
// through muldiv_step, and held on the result port until the consumer
// accepts it. A divide by zero skips the iteration and reports immediately.
//
// Ports
//   clk          in  1      clock, rising edge
//   rst          in  1      synchronous active-high reset
//   start_valid  in  1      request present
//   start_ready  out 1      unit idle and able to take a request
//   op           in  1      0 = multiply, 1 = divide
//   a, b         in  WIDTH  multiplicand/multiplier or dividend/divisor
//   res_valid    out 1      result present
//   res_ready    in  1      consumer takes the result
//   hi           out WIDTH  product upper half or remainder
//   lo           out WIDTH  product lower half or quotient
//   div_by_zero  out 1      result came from a divide with b == 0
// -----------------------------------------------------------------------------
module seq_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e           state_q,       state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    op_e              op_q,          op_d;
    logic [WIDTH-1:0] operand_q,     operand_d;
    logic [WIDTH-1:0] acc_hi_q,      acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q,      acc_lo_d;
    logic [WIDTH-1:0] hi_q,          hi_d;
    logic [WIDTH-1:0] lo_q,          lo_d;
    logic             dbz_q,         dbz_d;
    logic             start_ready_q, start_ready_d;
    logic             res_valid_q,   res_valid_d;

    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    // Both operations share one datapath: acc_hi starts at zero (partial
    // product or partial remainder) and acc_lo starts with a (multiplier or
    // dividend); b is the constant operand (multiplicand or divisor).
    muldiv_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .op      (op_q),
        .acc_hi  (acc_hi_q),
        .acc_lo  (acc_lo_q),
        .operand (operand_q),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        operand_d     = operand_q;
        acc_hi_d      = acc_hi_q;
        acc_lo_d      = acc_lo_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        dbz_d         = dbz_q;
        start_ready_d = start_ready_q;
        res_valid_d   = res_valid_q;

        case (state_q)
            IDLE: begin
                if (start_valid && start_ready_q) begin
                    op_d          = op_e'(op);
                    operand_d     = b;
                    start_ready_d = 1'b0;
                    if ((op_e'(op) == OP_DIV) && (b == '0)) begin
                        // Nothing to iterate: publish the fixed result now.
                        state_d     = DONE;
                        cnt_d       = '0;
                        hi_d        = a;
                        lo_d        = '1;
                        dbz_d       = 1'b1;
                        res_valid_d = 1'b1;
                    end else begin
                        state_d  = BUSY;
                        cnt_d    = CNT_W'(WIDTH - 1);
                        acc_hi_d = '0;
                        acc_lo_d = a;
                    end
                end
            end

            BUSY: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                if (cnt_q == '0) begin
                    // Last iteration: the step outputs are the final result,
                    // so they go straight to the visible registers.
                    state_d     = DONE;
                    hi_d        = step_hi;
                    lo_d        = step_lo;
                    dbz_d       = 1'b0;
                    res_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            DONE: begin
                if (res_ready) begin
                    state_d       = IDLE;
                    res_valid_d   = 1'b0;
                    start_ready_d = 1'b1;
                end
            end

            default: begin
                state_d       = IDLE;
                cnt_d         = '0;
                res_valid_d   = 1'b0;
                start_ready_d = 1'b1;
            end
        endcase
    end

    // Single state register; reset overrides any handshake on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            op_q          <= OP_MUL;
            operand_q     <= '0;
            acc_hi_q      <= '0;
            acc_lo_q      <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            dbz_q         <= 1'b0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            operand_q     <= operand_d;
            acc_hi_q      <= acc_hi_d;
            acc_lo_q      <= acc_lo_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            dbz_q         <= dbz_d;
            start_ready_q <= start_ready_d;
            res_valid_q   <= res_valid_d;
        end
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
